// File: rtl/pill_target_editor_pkg.sv
// Shared constants for the bottling front panel: controller state codes,
// cursor digit indices, 1 kHz timing defaults and the BCD digit step.
package pill_target_editor_pkg;

  typedef logic [2:0] ctrl_state_t;
  typedef logic [2:0] cursor_t;

  localparam ctrl_state_t ST_SETTING = 3'd0;
  localparam ctrl_state_t ST_FILLING = 3'd1;
  localparam ctrl_state_t ST_PAUSED  = 3'd2;
  localparam ctrl_state_t ST_DONE    = 3'd3;
  localparam ctrl_state_t ST_FATAL   = 3'd4;

  localparam cursor_t CUR_P1  = 3'd0;
  localparam cursor_t CUR_P2  = 3'd1;
  localparam cursor_t CUR_P3  = 3'd2;
  localparam cursor_t CUR_B1  = 3'd3;
  localparam cursor_t CUR_B2  = 3'd4;
  localparam cursor_t CUR_MAX = CUR_B2;

  // One clock is one millisecond.
  localparam int DEBOUNCE_MS_DEF      = 20;
  localparam int REPEAT_DELAY_MS_DEF  = 500;
  localparam int REPEAT_PERIOD_MS_DEF = 200;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/pill_target_editor_btn_debounce.sv
// Button debouncer: level follows raw after DEBOUNCE_MS equal differing samples;
// press is a one-cycle pulse the cycle after level rises.
module btn_debounce
  import pill_target_editor_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_MS + 1);

  logic [CW-1:0] cnt;
  logic          level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level & ~level_q;
      // Any sample that agrees with the current level restarts the count.
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_MS - 1)) begin
        level <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pill_target_editor.sv
// Operator target editor: debounced buttons edit five BCD digits under a cursor,
// increment auto-repeats while held; start/reject pulses are registered (1 cycle).
module pill_target_editor
  import pill_target_editor_pkg::*;
#(
  parameter int DEBOUNCE_MS      = DEBOUNCE_MS_DEF,
  parameter int REPEAT_DELAY_MS  = REPEAT_DELAY_MS_DEF,
  parameter int REPEAT_PERIOD_MS = REPEAT_PERIOD_MS_DEF
) (
  input  logic        clk_1khz,
  input  logic        switch_clr,
  input  logic        edit_en,
  input  logic        btn_sel_raw,
  input  logic        btn_inc_raw,
  input  logic        btn_start_raw,
  output logic [11:0] tgt_pills_bcd,
  output logic [7:0]  tgt_bottles_bcd,
  output logic [2:0]  cursor,
  output logic [4:0]  flicker_mask,
  output logic        cfg_valid,
  output logic        cfg_start,
  output logic        cfg_reject
);

  localparam logic [1:0] RPT_IDLE   = 2'd0;
  localparam logic [1:0] RPT_HOLD   = 2'd1;
  localparam logic [1:0] RPT_REPEAT = 2'd2;

  localparam int TMAX = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ? REPEAT_DELAY_MS : REPEAT_PERIOD_MS;
  localparam int TW   = $clog2(TMAX + 1);

  logic            sel_lvl, sel_press;
  logic            inc_lvl, inc_press;
  logic            start_lvl, start_press;
  logic [1:0]      unused_lvl;
  logic [4:0][3:0] digits;
  logic [1:0]      rpt, rpt_next;
  logic [TW-1:0]   timer, timer_next;
  logic            rpt_step;
  logic            sel_go, inc_go, start_go, step;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_sel (
    .clk(clk_1khz), .rst_n(switch_clr), .raw(btn_sel_raw), .level(sel_lvl), .press(sel_press)
  );
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_inc (
    .clk(clk_1khz), .rst_n(switch_clr), .raw(btn_inc_raw), .level(inc_lvl), .press(inc_press)
  );
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start (
    .clk(clk_1khz), .rst_n(switch_clr), .raw(btn_start_raw), .level(start_lvl), .press(start_press)
  );

  assign unused_lvl = {sel_lvl, start_lvl};

  assign sel_go   = edit_en & sel_press;
  assign inc_go   = edit_en & inc_press;
  assign start_go = edit_en & start_press;
  assign step     = inc_go | rpt_step;

  assign tgt_pills_bcd   = {digits[2], digits[1], digits[0]};
  assign tgt_bottles_bcd = {digits[4], digits[3]};
  assign cfg_valid       = (tgt_pills_bcd != 12'd0) && (tgt_bottles_bcd != 8'd0);
  assign flicker_mask    = edit_en ? (5'b00001 << cursor) : 5'b00000;

  always_comb begin
    rpt_next   = rpt;
    timer_next = timer;
    rpt_step   = 1'b0;
    case (rpt)
      RPT_IDLE: begin
        if (inc_go) begin
          rpt_next   = RPT_HOLD;
          timer_next = '0;
        end
      end
      RPT_HOLD: begin
        if (!inc_lvl || !edit_en) begin
          rpt_next = RPT_IDLE;
        end else if (timer == TW'(REPEAT_DELAY_MS - 1)) begin
          rpt_step   = 1'b1;
          rpt_next   = RPT_REPEAT;
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      RPT_REPEAT: begin
        if (!inc_lvl || !edit_en) begin
          rpt_next = RPT_IDLE;
        end else if (timer == TW'(REPEAT_PERIOD_MS - 1)) begin
          rpt_step   = 1'b1;
          timer_next = '0;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: rpt_next = RPT_IDLE;
    endcase
  end

  always_ff @(posedge clk_1khz or negedge switch_clr) begin
    if (!switch_clr) begin
      rpt        <= RPT_IDLE;
      timer      <= '0;
      digits     <= '0;
      cursor     <= CUR_P1;
      cfg_start  <= 1'b0;
      cfg_reject <= 1'b0;
    end else begin
      rpt        <= rpt_next;
      timer      <= timer_next;
      cfg_start  <= start_go & cfg_valid;
      cfg_reject <= start_go & ~cfg_valid;
      // A start press judges the pre-edit config, so same-cycle edits are dropped.
      if (!start_go) begin
        for (int i = 0; i < 5; i++) begin
          if (step && cursor == 3'(i)) digits[i] <= bcd_inc(digits[i]);
        end
        if (sel_go) cursor <= (cursor == CUR_MAX) ? CUR_P1 : cursor + 3'd1;
      end
    end
  end

endmodule
